// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates three cache/DMA ports onto one SDRAM controller that moves
// 4-word bursts. A grant latches the owner, direction and burst address.
// The controller handshake (ready/offset, write data) is steered
// combinationally between the controller and the owning port.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, rotating
// priority is used and the port that just finished a burst drops to lowest
// priority. When it is undefined, fixed priority p3 > p2 > p1 is used.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    // program cache (read only)
    input  logic        p1_req,
    input  logic [31:0] p1_address,
    output logic        p1_ready,
    output logic [1:0]  p1_offset,
    // data cache
    input  logic        p2_req,
    input  logic        p2_wren,
    input  logic [31:0] p2_address,
    input  logic [15:0] p2_to_mem,
    output logic        p2_ready,
    output logic [1:0]  p2_offset,
    // video / DMA
    input  logic        p3_req,
    input  logic        p3_wren,
    input  logic [16:0] p3_address,
    input  logic [15:0] p3_to_mem,
    output logic        p3_ready,
    output logic [1:0]  p3_offset,
    // shared read data
    output logic [15:0] from_mem,
    // SDRAM controller
    output logic        ctrl_req,
    output logic        ctrl_wren,
    output logic [23:0] ctrl_address,
    output logic [15:0] ctrl_to_mem,
    input  logic        ctrl_ready,
    input  logic [1:0]  ctrl_offset,
    input  logic [15:0] ctrl_from_mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Owner / port codes; code 0 means no port owns the controller.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P1   = 2'd1;
    localparam logic [1:0] OWN_P2   = 2'd2;
    localparam logic [1:0] OWN_P3   = 2'd3;

    state_t      r_state;
    logic [1:0]  r_owner;
    logic        r_ctrl_req;
    logic        r_ctrl_wren;
    logic [23:0] r_ctrl_address;
    logic [1:0]  r_beat_cnt;

    logic [2:0]  w_req_vec;
    logic [1:0]  w_grant_owner;
    logic        w_grant_wren;
    logic [23:0] w_grant_address;
    logic        w_last_beat;
    logic        w_unused;

    // Next port in the rotation p1 -> p2 -> p3 -> p1.
    function automatic logic [1:0] next_port(input logic [1:0] port);
        logic [1:0] nxt;
        case (port)
            OWN_P1:  nxt = OWN_P2;
            OWN_P2:  nxt = OWN_P3;
            default: nxt = OWN_P1;
        endcase
        return nxt;
    endfunction

    // True when the given port code has its request line asserted.
    function automatic logic port_requested(input logic [1:0] port, input logic [2:0] reqs);
        logic hit;
        case (port)
            OWN_P1:  hit = reqs[0];
            OWN_P2:  hit = reqs[1];
            OWN_P3:  hit = reqs[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign w_req_vec = {p3_req, p2_req, p1_req};

    // Address bits that never reach the controller (word-in-burst and high bits).
    assign w_unused = ^{p1_address[31:24], p1_address[1:0],
                        p2_address[31:24], p2_address[1:0], p3_address[1:0]};

    // The fourth ready beat of a burst closes it.
    assign w_last_beat = (r_state == BUSY) && ctrl_ready && (r_beat_cnt == 2'd3);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;

    assign w_cand0 = r_rr_ptr;
    assign w_cand1 = next_port(w_cand0);
    assign w_cand2 = next_port(w_cand1);

    // Rotating priority: start the search at the pointer and walk the ring.
    always_comb begin
        w_grant_owner = OWN_NONE;
        if (port_requested(w_cand0, w_req_vec)) begin
            w_grant_owner = w_cand0;
        end else if (port_requested(w_cand1, w_req_vec)) begin
            w_grant_owner = w_cand1;
        end else if (port_requested(w_cand2, w_req_vec)) begin
            w_grant_owner = w_cand2;
        end else begin
            w_grant_owner = OWN_NONE;
        end
    end

    // The port that just completed a burst becomes lowest priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr <= OWN_P1;
        end else if (w_last_beat) begin
            r_rr_ptr <= next_port(r_owner);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    // Fixed priority: p3 (video) over p2 (data) over p1 (program).
    always_comb begin
        w_grant_owner = OWN_NONE;
        if (port_requested(OWN_P3, w_req_vec)) begin
            w_grant_owner = OWN_P3;
        end else if (port_requested(OWN_P2, w_req_vec)) begin
            w_grant_owner = OWN_P2;
        end else if (port_requested(OWN_P1, w_req_vec)) begin
            w_grant_owner = OWN_P1;
        end else begin
            w_grant_owner = OWN_NONE;
        end
    end
`endif

    // Burst-aligned controller address and direction for the winning port.
    always_comb begin
        w_grant_address = 24'd0;
        w_grant_wren    = 1'b0;
        case (w_grant_owner)
            OWN_P1: begin
                w_grant_address = {p1_address[23:2], 2'b00};
                w_grant_wren    = 1'b0;
            end
            OWN_P2: begin
                w_grant_address = {p2_address[23:2], 2'b00};
                w_grant_wren    = p2_wren;
            end
            OWN_P3: begin
                w_grant_address = {7'h7F, p3_address[16:2], 2'b00};
                w_grant_wren    = p3_wren;
            end
            default: begin
                w_grant_address = 24'd0;
                w_grant_wren    = 1'b0;
            end
        endcase
    end

    // Arbitration FSM: grant in IDLE, count beats in BUSY, one-cycle DONE gap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_owner        <= OWN_NONE;
            r_ctrl_req     <= 1'b0;
            r_ctrl_wren    <= 1'b0;
            r_ctrl_address <= 24'd0;
            r_beat_cnt     <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_owner != OWN_NONE) begin
                        r_owner        <= w_grant_owner;
                        r_ctrl_wren    <= w_grant_wren;
                        r_ctrl_address <= w_grant_address;
                        r_ctrl_req     <= 1'b1;
                        r_beat_cnt     <= 2'd0;
                        r_state        <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (ctrl_ready) begin
                        r_beat_cnt <= r_beat_cnt + 2'd1;
                        if (r_beat_cnt == 2'd3) begin
                            r_ctrl_req  <= 1'b0;
                            r_ctrl_wren <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_state <= BUSY;
                        end
                    end else begin
                        r_state <= BUSY;
                    end
                end
                DONE: begin
                    r_owner <= OWN_NONE;
                    r_state <= IDLE;
                end
                default: begin
                    r_owner    <= OWN_NONE;
                    r_ctrl_req <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // Forward the controller handshake to the owner only while a burst runs.
    always_comb begin
        p1_ready  = 1'b0;
        p1_offset = 2'd0;
        p2_ready  = 1'b0;
        p2_offset = 2'd0;
        p3_ready  = 1'b0;
        p3_offset = 2'd0;
        if (r_state == BUSY) begin
            case (r_owner)
                OWN_P1: begin
                    p1_ready  = ctrl_ready;
                    p1_offset = ctrl_offset;
                end
                OWN_P2: begin
                    p2_ready  = ctrl_ready;
                    p2_offset = ctrl_offset;
                end
                OWN_P3: begin
                    p3_ready  = ctrl_ready;
                    p3_offset = ctrl_offset;
                end
                default: begin
                    p1_ready = 1'b0;
                end
            endcase
        end else begin
            p1_ready = 1'b0;
        end
    end

    // Write data comes straight from the owner for the word on the bus now.
    always_comb begin
        case (r_owner)
            OWN_P2:  ctrl_to_mem = p2_to_mem;
            OWN_P3:  ctrl_to_mem = p3_to_mem;
            default: ctrl_to_mem = 16'd0;
        endcase
    end

    assign ctrl_req     = r_ctrl_req;
    assign ctrl_wren    = r_ctrl_wren;
    assign ctrl_address = r_ctrl_address;
    assign from_mem     = ctrl_from_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a beat scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p1_req, p1_ready;
    logic [31:0] p1_address;
    logic [1:0]  p1_offset;
    logic        p2_req, p2_wren, p2_ready;
    logic [31:0] p2_address;
    logic [15:0] p2_to_mem;
    logic [1:0]  p2_offset;
    logic        p3_req, p3_wren, p3_ready;
    logic [16:0] p3_address;
    logic [15:0] p3_to_mem;
    logic [1:0]  p3_offset;
    logic [15:0] from_mem;
    logic        ctrl_req, ctrl_wren, ctrl_ready;
    logic [23:0] ctrl_address;
    logic [15:0] ctrl_to_mem, ctrl_from_mem;
    logic [1:0]  ctrl_offset;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p1_address(p1_address), .p1_ready(p1_ready), .p1_offset(p1_offset),
        .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
        .p2_ready(p2_ready), .p2_offset(p2_offset),
        .p3_req(p3_req), .p3_wren(p3_wren), .p3_address(p3_address), .p3_to_mem(p3_to_mem),
        .p3_ready(p3_ready), .p3_offset(p3_offset),
        .from_mem(from_mem),
        .ctrl_req(ctrl_req), .ctrl_wren(ctrl_wren), .ctrl_address(ctrl_address),
        .ctrl_to_mem(ctrl_to_mem), .ctrl_ready(ctrl_ready), .ctrl_offset(ctrl_offset),
        .ctrl_from_mem(ctrl_from_mem)
    );

    typedef struct {
        int          port;
        logic [1:0]  off;
        logic [15:0] rdata;
        logic [15:0] wdata;
        bit          chk_w;
    } beat_t;

    beat_t sb[$];
    int total = 0;
    int bad   = 0;

    localparam logic [15:0] IDLE_W2 = 16'hBAD2;
    localparam logic [15:0] IDLE_W3 = 16'hBAD3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v);
        case (p)
            1: p1_req = v;
            2: p2_req = v;
            3: p3_req = v;
            default: ;
        endcase
    endtask

    // Wait (bounded) for the controller request and check latched command.
    task automatic wait_grant(input logic [23:0] ea, input logic ew, input int exp_lat);
        int n = 0;
        while (!ctrl_req && n < 20) begin
            tick();
            n++;
        end
        chk("grant_latency", n, exp_lat);
        chk("ctrl_address", ctrl_address, ea);
        chk("ctrl_wren", {31'd0, ctrl_wren}, {31'd0, ew});
    endtask

    // Present one controller beat, record the expectation, compare at negedge.
    task automatic drive_beat(input int p, input logic [1:0] b, input bit wchk,
                              input logic [23:0] ea, input logic ew);
        beat_t e;
        beat_t g;
        logic [15:0] d;
        d = 16'($urandom);
        ctrl_ready    = 1'b1;
        ctrl_offset   = b;
        ctrl_from_mem = d;
        if (p == 2) p2_to_mem = 16'(b) * 16'h1111;
        else if (p == 3) p3_to_mem = 16'(b) * 16'h1111;
        e.port = p; e.off = b; e.rdata = d; e.wdata = 16'(b) * 16'h1111; e.chk_w = wchk;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("ready_vec", {29'd0, p3_ready, p2_ready, p1_ready}, 32'(3'b001 << (g.port - 1)));
        chk("offset_vec", {26'd0, p3_offset, p2_offset, p1_offset},
            32'(6'(g.off) << (2 * (g.port - 1))));
        chk("from_mem", {16'd0, from_mem}, {16'd0, g.rdata});
        if (g.chk_w) chk("ctrl_to_mem", {16'd0, ctrl_to_mem}, {16'd0, g.wdata});
        chk("addr_stable", ctrl_address, ea);
        chk("wren_stable", {31'd0, ctrl_wren}, {31'd0, ew});
        tick();
        ctrl_ready = 1'b0;
        p2_to_mem  = IDLE_W2;
        p3_to_mem  = IDLE_W3;
    endtask

    // Full 4-beat burst, then probe the single DONE cycle.
    task automatic run_burst(input int p, input logic [23:0] ea, input logic ew, input bit wchk,
                             input bit drop_mid, input bit keep_req);
        for (int b = 0; b < 4; b++) begin
            drive_beat(p, 2'(b), wchk, ea, ew);
            if (b == 0 && drop_mid) set_req(p, 1'b0);
            if (b < 3) chk("req_held", {31'd0, ctrl_req}, 32'd1);
        end
        chk("req_dropped", {31'd0, ctrl_req}, 32'd0);
        if (!keep_req) set_req(p, 1'b0);
        ctrl_ready  = 1'b1;
        ctrl_offset = 2'd2;
        #1;
        chk("done_no_ready", {29'd0, p3_ready, p2_ready, p1_ready}, 32'd0);
        chk("done_no_offset", {26'd0, p3_offset, p2_offset, p1_offset}, 32'd0);
        ctrl_ready  = 1'b0;
        ctrl_offset = 2'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        p1_req = 1'b0; p1_address = 32'd0;
        p2_req = 1'b0; p2_wren = 1'b0; p2_address = 32'd0; p2_to_mem = IDLE_W2;
        p3_req = 1'b0; p3_wren = 1'b0; p3_address = 17'd0; p3_to_mem = IDLE_W3;
        ctrl_ready = 1'b0; ctrl_offset = 2'd0; ctrl_from_mem = 16'd0;
        repeat (3) tick();

        // reset state, with a stray ready from the controller
        ctrl_ready = 1'b1; ctrl_offset = 2'd3;
        #1;
        chk("rst_ctrl_req", {31'd0, ctrl_req}, 32'd0);
        chk("rst_ctrl_wren", {31'd0, ctrl_wren}, 32'd0);
        chk("rst_ctrl_address", ctrl_address, 24'd0);
        chk("rst_ready", {29'd0, p3_ready, p2_ready, p1_ready}, 32'd0);
        chk("rst_offset", {26'd0, p3_offset, p2_offset, p1_offset}, 32'd0);
        ctrl_ready = 1'b0; ctrl_offset = 2'd0;

        // single read on p1, granted on the first cycle out of reset
        reset = 1'b1;
        p1_address = 32'h0000_1237;
        p1_req = 1'b1;
        wait_grant(24'h001234, 1'b0, 1);
        run_burst(1, 24'h001234, 1'b0, 1'b0, 1'b0, 1'b0);

        // p2 write requested during DONE; port inputs change mid-burst
        p2_address = 32'h0000_0040; p2_wren = 1'b1; p2_req = 1'b1;
        wait_grant(24'h000040, 1'b1, 2);
        p2_address = 32'hFFFF_FFFF; p2_wren = 1'b0;
        run_burst(2, 24'h000040, 1'b1, 1'b1, 1'b0, 1'b0);
        p2_address = 32'h0000_0040;

        // contention: all three asserted in the same cycle out of reset
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        p3_address = 17'h1FFFC; p3_wren = 1'b0;
        p1_req = 1'b1; p2_req = 1'b1; p3_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        wait_grant(24'h001234, 1'b0, 1);
        run_burst(1, 24'h001234, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_grant(24'h000040, 1'b0, 2);
        run_burst(2, 24'h000040, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_grant(24'hFFFFFC, 1'b0, 2);
        run_burst(3, 24'hFFFFFC, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_grant(24'h001234, 1'b0, 2);
        run_burst(1, 24'h001234, 1'b0, 1'b0, 1'b0, 1'b1);
        p1_req = 1'b0; p2_req = 1'b0; p3_req = 1'b0;
`else
        wait_grant(24'hFFFFFC, 1'b0, 1);
        run_burst(3, 24'hFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_grant(24'h000040, 1'b0, 2);
        run_burst(2, 24'h000040, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_grant(24'h001234, 1'b0, 2);
        run_burst(1, 24'h001234, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // reset after beat 1 of a p2 burst
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        p2_wren = 1'b0; p2_req = 1'b1;
        wait_grant(24'h000040, 1'b0, 1);
        drive_beat(2, 2'd0, 1'b0, 24'h000040, 1'b0);
        drive_beat(2, 2'd1, 1'b0, 24'h000040, 1'b0);
        reset = 1'b0;
        tick();
        ctrl_ready = 1'b1; ctrl_offset = 2'd2;
        #1;
        chk("abort_ctrl_req", {31'd0, ctrl_req}, 32'd0);
        chk("abort_ready", {29'd0, p3_ready, p2_ready, p1_ready}, 32'd0);
        ctrl_ready = 1'b0; ctrl_offset = 2'd0;
        p2_req = 1'b0;
        reset = 1'b1;
        p1_req = 1'b1;
        wait_grant(24'h001234, 1'b0, 1);
        run_burst(1, 24'h001234, 1'b0, 1'b0, 1'b0, 1'b0);

        // ready pulsed in IDLE, then a p2 burst whose request is withdrawn
        tick();
        ctrl_ready = 1'b1; ctrl_offset = 2'd3;
        #1;
        chk("idle_no_ready", {29'd0, p3_ready, p2_ready, p1_ready}, 32'd0);
        tick();
        chk("idle_no_offset", {26'd0, p3_offset, p2_offset, p1_offset}, 32'd0);
        ctrl_ready = 1'b0; ctrl_offset = 2'd0;
        p2_req = 1'b1;
        wait_grant(24'h000040, 1'b0, 1);
        run_burst(2, 24'h000040, 1'b0, 1'b0, 1'b1, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-003 SHALL have ports p1_req in 1, p1_address in 32, p1_ready out 1, p1_offset out 2: read-only port for the program cache.
REQ-004 SHALL have ports p2_req in 1, p2_wren in 1, p2_address in 32, p2_to_mem in 16, p2_ready out 1, p2_offset out 2: read/write port for the data cache.
REQ-005 SHALL have ports p3_req in 1, p3_wren in 1, p3_address in 17, p3_to_mem in 16, p3_ready out 1, p3_offset out 2: read/write port for the video/DMA path.
REQ-006 SHALL have port from_mem, output, 16: read data, shared by all ports, valid when the owning pN_ready is high.
REQ-007 SHALL have ports ctrl_req out 1, ctrl_wren out 1, ctrl_address out 24, ctrl_to_mem out 16, ctrl_ready in 1, ctrl_offset in 2, ctrl_from_mem in 16: SDRAM controller side, 4-word bursts.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-009 SHALL, in IDLE, grant the highest-priority asserted request; fixed priority is p3 > p2 > p1.
REQ-010 SHALL, on grant, register the owner, ctrl_wren and ctrl_address, and set ctrl_req=1 on the next cycle (BUSY).
REQ-011 SHALL form ctrl_address with bits [1:0] forced to 0.
- p1/p2: ctrl_address = address[23:2]:00.
- p3: ctrl_address = {7'h7F, p3_address[16:2], 2'b00}.
REQ-012 SHALL hold ctrl_address and ctrl_wren stable for the whole of BUSY, regardless of port input changes.
REQ-013 SHALL drive the owner's pN_ready = ctrl_ready and pN_offset = ctrl_offset combinationally; non-owners SHALL see ready=0 and offset=0.
REQ-014 SHALL route ctrl_to_mem combinationally from the owner's to_mem.
- The port presents the word for the current ctrl_offset in the same cycle as ctrl_ready.
REQ-015 SHALL pass ctrl_from_mem to from_mem unregistered.
REQ-016 SHALL count ready beats with a 2-bit counter; the 4th beat (counter=3 with ctrl_ready=1) ends the burst.
REQ-017 SHALL, on the last beat, drop ctrl_req the next cycle and enter DONE for exactly one cycle, then return to IDLE.
- No grant is made in DONE.
- Requesters SHALL deassert req the cycle after their last ready.
REQ-018 SHALL ignore ctrl_ready while in IDLE or DONE: no ready is forwarded and the counter is unchanged.
REQ-019 SHALL ignore new or withdrawn requests during BUSY; a req dropped mid-burst does not abort the burst.
REQ-020 SHALL resolve simultaneous requests in one cycle per REQ-009 (or REQ-024); losers wait with no data lost.

Reset
REQ-021 SHALL, while reset=0 at a clock edge, enter IDLE with beat counter=0, owner=none and ctrl_req=0.
- ctrl_wren=0, ctrl_address=0.
- All pN_ready=0, all pN_offset=0.
- Round-robin pointer set to p1 highest.
REQ-022 SHALL abandon any in-flight burst on reset mid-operation, with no further ready forwarded.
REQ-023 SHALL accept a new grant on the first cycle after reset is released.

Configuration
REQ-024 SHALL, with ARB_ROUND_ROBIN_EN defined, use rotating priority.
- After each completed burst, the finishing owner becomes lowest priority.
- Initial order after reset is p1 > p2 > p3.
REQ-025 SHALL, with ARB_ROUND_ROBIN_EN undefined, use the fixed priority of REQ-009 and contain no rotation state.

Verification
REQ-026 Single read: p1_req with p1_address=32'h0000_1237 -> ctrl_address=24'h001234, ctrl_wren=0; p1_ready pulses offsets 0..3 with from_mem=ctrl_from_mem; ctrl_req drops after beat 3; one DONE cycle.
REQ-027 Write: p2_req, p2_wren=1, p2_address=32'h0000_0040, to_mem=offset*16'h1111 -> ctrl_to_mem=0000,1111,2222,3333 on successive beats.
REQ-028 Contention (fixed): p1, p2 and p3 requests in the same cycle -> grant order p3, p2, p1; each burst is separated by a DONE cycle; p3_address=17'h1FFFC maps to 24'hFFFFFC.
REQ-029 Contention (ARB_ROUND_ROBIN_EN): all three requests held continuously -> grant order p1, p2, p3, p1.
REQ-030 Reset after beat 1 of a p2 burst -> next-cycle ctrl_req=0 and p2_ready=0; a subsequent p1_req is granted normally.
REQ-031 ctrl_ready pulsed in IDLE, and p2_req withdrawn mid-burst -> no pN_ready on the IDLE pulse; the burst still completes 4 beats.
